// File: rtl/calc_entry_engine.sv
// Calculator core: builds signed decimal operands from keypad pulses, applies +, - or x
// (multiply via a 14-step shift-add) and drives the signed display value and status flags.
module calc_entry_engine #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAX_MAG = 99999999
) (
  input  logic                    newClock,
  input  logic                    reset,
  input  logic [4:0]              numberPulse,
  input  logic [4:0]              operatorPulse,
  input  logic [4:0]              equalPulse,
  input  logic [4:0]              clearPulse,
  input  logic [4:0]              resetPulse,
  input  logic [4:0]              negativePulse,
  output logic signed [WIDTH-1:0] displayValue,
  output logic                    busy,
  output logic                    error,
  output logic [2:0]              state
);

  localparam int unsigned ACC_W = 48;
  localparam int unsigned MAG_W = 14;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned ITER  = 14;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_COMPUTE = 3'd2,
    S_SHOW    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2} op_t;

  typedef enum logic [3:0] {
    ACT_NONE, ACT_RESET, ACT_CLEAR, ACT_EQ, ACT_CHAIN, ACT_OP_A,
    ACT_OP_REPL, ACT_SHOW_OP, ACT_DIGIT, ACT_NEW_A, ACT_NEG
  } act_t;

  state_t                   st;
  op_t                      op, pend_op, op_dec;
  act_t                     act;
  logic [MAG_W-1:0]         mag, next_mag;
  logic [CNT_W-1:0]         cnt;
  logic                     sign, chain, mneg, op_ok, is_digit;
  logic signed [ACC_W-1:0]  a, b, ent_val, sum, fin_val;
  logic [ACC_W-1:0]         ent_mag, a_mag, acc, mcand, mul_acc, fin_mag;
  logic [MAG_W-1:0]         mplier;
  logic [3:0]               mcnt;
  logic                     fin_neg, fin_ovf, mul_last;
  logic                     unused_bits;

  assign state       = st;
  assign unused_bits = ^{equalPulse[3:0], clearPulse[3:0], resetPulse[3:0], negativePulse[3:1]};

  function automatic logic signed [WIDTH-1:0] disp_of(input logic s, input logic [MAG_W-1:0] m);
    logic [WIDTH-1:0] v;
    v = WIDTH'(m);
    return s ? -v : v;
  endfunction

  // Operand, operator and arithmetic datapath
  always_comb begin
    is_digit = numberPulse[3:0] <= 4'd9;
    next_mag = MAG_W'(mag * MAG_W'(10) + MAG_W'(numberPulse[3:0]));
    op_ok    = 1'b1;
    case (operatorPulse[3:0])
      4'hF:    op_dec = OP_ADD;
      4'hE:    op_dec = OP_SUB;
      4'hD:    op_dec = OP_MUL;
      default: begin op_dec = OP_ADD; op_ok = 1'b0; end
    endcase
    ent_mag  = ACC_W'(mag);
    ent_val  = sign ? -ent_mag : ent_mag;
    a_mag    = a[ACC_W-1] ? -a : a;
    sum      = (op == OP_SUB) ? a - b : a + b;
    mul_acc  = acc + (mplier[0] ? mcand : '0);
    mul_last = mcnt == 4'(ITER - 1);
    if (op == OP_MUL) begin
      fin_mag = mul_acc;
      fin_neg = mneg;
    end else begin
      fin_mag = sum[ACC_W-1] ? -sum : sum;
      fin_neg = sum[ACC_W-1];
    end
    fin_val = (fin_neg && fin_mag != '0) ? -fin_mag : fin_mag;
    fin_ovf = fin_mag > ACC_W'(MAX_MAG);
  end

  // Pick the single highest-priority pulse and what it means in the current state
  always_comb begin
    act = ACT_NONE;
    if (resetPulse[4] || (clearPulse[4] && (st == S_SHOW || st == S_ERROR))) begin
      act = ACT_RESET;
    end else if (st == S_ENTER_A || st == S_ENTER_B) begin
      if (clearPulse[4]) act = ACT_CLEAR;
      else if (equalPulse[4]) act = (st == S_ENTER_B) ? ACT_EQ : ACT_NONE;
      else if (operatorPulse[4]) begin
        if (op_ok) begin
          if (st == S_ENTER_A) act = ACT_OP_A;
          else if (cnt == '0) act = ACT_OP_REPL;
          else act = ACT_CHAIN;
        end
      end else if (numberPulse[4]) begin
        if (is_digit && cnt < CNT_W'(DIGITS)) act = ACT_DIGIT;
      end else if (negativePulse[4]) act = ACT_NEG;
    end else if (st == S_SHOW) begin
      if (equalPulse[4]) act = ACT_NONE;
      else if (operatorPulse[4]) act = op_ok ? ACT_SHOW_OP : ACT_NONE;
      else if (numberPulse[4]) act = is_digit ? ACT_NEW_A : ACT_NONE;
    end
  end

  always_ff @(posedge newClock) begin
    if (reset || act == ACT_RESET) begin
      st           <= S_ENTER_A;
      displayValue <= '0;
      busy         <= 1'b0;
      error        <= 1'b0;
      mag          <= '0;
      cnt          <= '0;
      sign         <= 1'b0;
      a            <= '0;
      b            <= '0;
      op           <= OP_ADD;
      pend_op      <= OP_ADD;
      chain        <= 1'b0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      mcnt         <= '0;
      mneg         <= 1'b0;
    end else begin
      case (act)
        ACT_CLEAR: begin
          mag <= '0; cnt <= '0; sign <= 1'b0; displayValue <= '0;
        end
        ACT_EQ, ACT_CHAIN: begin
          b       <= ent_val;
          st      <= S_COMPUTE;
          busy    <= 1'b1;
          acc     <= '0;
          mcand   <= a_mag;
          mplier  <= mag;
          mcnt    <= '0;
          mneg    <= a[ACC_W-1] ^ sign;
          chain   <= (act == ACT_CHAIN);
          pend_op <= op_dec;
          mag <= '0; cnt <= '0; sign <= 1'b0;
        end
        ACT_OP_A: begin
          a  <= ent_val;
          op <= op_dec;
          st <= S_ENTER_B;
          mag <= '0; cnt <= '0; sign <= 1'b0;
        end
        ACT_OP_REPL: op <= op_dec;
        ACT_SHOW_OP: begin
          a  <= {{(ACC_W-WIDTH){displayValue[WIDTH-1]}}, displayValue};
          op <= op_dec;
          st <= S_ENTER_B;
          mag <= '0; cnt <= '0; sign <= 1'b0;
        end
        ACT_DIGIT: begin
          mag          <= next_mag;
          cnt          <= cnt + CNT_W'(1);
          displayValue <= disp_of(sign, next_mag);
        end
        ACT_NEW_A: begin
          mag          <= MAG_W'(numberPulse[3:0]);
          cnt          <= CNT_W'(1);
          sign         <= 1'b0;
          st           <= S_ENTER_A;
          displayValue <= WIDTH'(numberPulse[3:0]);
        end
        ACT_NEG: begin
          sign         <= negativePulse[0];
          displayValue <= disp_of(negativePulse[0], mag);
        end
        default: ;
      endcase

      // One shift-add step per cycle; add/sub finishes on the first COMPUTE cycle
      if (st == S_COMPUTE) begin
        acc    <= mul_acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        mcnt   <= mcnt + 4'd1;
        if (op != OP_MUL || mul_last) begin
          busy  <= 1'b0;
          chain <= 1'b0;
          if (fin_ovf) begin
            error        <= 1'b1;
            displayValue <= '0;
            st           <= S_ERROR;
          end else begin
            displayValue <= WIDTH'(fin_val);
            if (chain) begin
              a  <= fin_val;
              op <= pend_op;
              st <= S_ENTER_B;
            end else begin
              st <= S_SHOW;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_entry_engine.sv
// Directed scoreboard bench for calc_entry_engine: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_calc_entry_engine;

  localparam logic [2:0] EA = 3'd0, EB = 3'd1, CP = 3'd2, SH = 3'd3, ER = 3'd4;

  logic        newClock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  numberPulse = '0, operatorPulse = '0, equalPulse = '0;
  logic [4:0]  clearPulse = '0, resetPulse = '0, negativePulse = '0;
  logic signed [31:0] displayValue;
  logic        busy, error;
  logic [2:0]  state;

  calc_entry_engine dut (
    .newClock(newClock), .reset(reset),
    .numberPulse(numberPulse), .operatorPulse(operatorPulse),
    .equalPulse(equalPulse), .clearPulse(clearPulse),
    .resetPulse(resetPulse), .negativePulse(negativePulse),
    .displayValue(displayValue), .busy(busy), .error(error), .state(state)
  );

  always #5 newClock = ~newClock;

  int cyc = 0;
  always @(posedge newClock) cyc <= cyc + 1;

  typedef struct {
    int          when;
    string       name;
    bit          chk_disp;
    logic [31:0] disp;
    logic [2:0]  st;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   le = 0;

  task automatic expect_at(int when, string name, bit cd, logic [31:0] d,
                           logic [2:0] s, logic bz, logic e);
    exp_t x;
    x.when = when; x.name = name; x.chk_disp = cd; x.disp = d;
    x.st = s; x.busy = bz; x.err = e;
    q.push_back(x);
  endtask

  task automatic ex(string name, logic [31:0] d, logic [2:0] s);
    expect_at(le, name, 1'b1, d, s, 1'b0, 1'b0);
  endtask

  task automatic exs(string name, logic [2:0] s);
    expect_at(le, name, 1'b0, '0, s, 1'b0, 1'b0);
  endtask

  // Advance to the next negedge, drop all pulses; le = edge that samples new drives
  task automatic tick();
    @(negedge newClock);
    reset = 1'b0;
    numberPulse = '0; operatorPulse = '0; equalPulse = '0;
    clearPulse = '0; resetPulse = '0; negativePulse = '0;
    le = cyc + 1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic num(int d);
    tick(); numberPulse = {1'b1, 4'(d)};
  endtask

  task automatic oper(logic [3:0] c);
    tick(); operatorPulse = {1'b1, c};
  endtask

  task automatic eq();
    tick(); equalPulse = 5'h10;
  endtask

  task automatic clr();
    tick(); clearPulse = 5'h10;
  endtask

  task automatic neg(logic s);
    tick(); negativePulse = {4'h8, s};
  endtask

  always @(negedge newClock) begin
    while (q.size() > 0 && q[0].when <= cyc) begin
      exp_t x;
      x = q.pop_front();
      vectors++;
      if (x.when != cyc || (x.chk_disp && displayValue !== x.disp) || state !== x.st ||
          busy !== x.busy || error !== x.err) begin
        miscompares++;
        $display("FAIL %s @%0d: got disp=%h state=%0d busy=%b error=%b, want disp=%h state=%0d busy=%b error=%b%s",
                 x.name, cyc, displayValue, state, busy, error,
                 x.disp, x.st, x.busy, x.err, x.chk_disp ? "" : " (disp not checked)");
      end
    end
  end

  initial begin
    int le_eq;

    tick(); reset = 1'b1; ex("reset", 0, EA);

    // 123 + 45
    num(1); ex("d1", 1, EA);
    num(2); ex("d12", 12, EA);
    num(3); ex("d123", 123, EA);
    oper(4'hF); exs("op_add", EB);
    num(4); ex("b4", 4, EB);
    num(5); ex("b45", 45, EB);
    eq(); expect_at(le, "add_busy", 1'b0, '0, CP, 1'b1, 1'b0);
    expect_at(le + 1, "add_res", 1'b1, 32'd168, SH, 1'b0, 1'b0);
    idle(1);

    // -7 x 12
    clr(); ex("clr_show", 0, EA);
    neg(1'b1); ex("neg0", 0, EA);
    num(7); ex("neg7", 32'hFFFF_FFF9, EA);
    oper(4'hD); exs("op_mul", EB);
    num(1); num(2); ex("b12", 12, EB);
    eq();
    for (int i = 0; i < 14; i++) expect_at(le + i, "mul_busy", 1'b0, '0, CP, 1'b1, 1'b0);
    expect_at(le + 14, "mul_res", 1'b1, 32'hFFFF_FFAC, SH, 1'b0, 1'b0);
    idle(14);

    // digit limit, large multiply, overflow, error recovery
    clr(); ex("clr2", 0, EA);
    repeat (4) num(9); ex("a9999", 9999, EA);
    num(9); ex("fifth_ignored", 9999, EA);
    oper(4'hD);
    repeat (4) num(9); ex("b9999", 9999, EB);
    eq(); expect_at(le + 14, "big_mul", 1'b1, 32'd99980001, SH, 1'b0, 1'b0);
    idle(14);
    oper(4'hD); exs("show_op", EB);
    num(2); ex("b2", 2, EB);
    eq(); expect_at(le + 14, "overflow", 1'b1, 32'd0, ER, 1'b0, 1'b1);
    idle(14);
    num(5); expect_at(le, "err_ignores_num", 1'b1, 32'd0, ER, 1'b0, 1'b1);
    clr(); ex("err_clear", 0, EA);

    // chaining 5 + 3 - 2
    num(5); oper(4'hF); num(3); oper(4'hE);
    expect_at(le + 1, "chain", 1'b1, 32'd8, EB, 1'b0, 1'b0);
    idle(1);
    num(2); ex("chain_b2", 2, EB);
    eq(); expect_at(le + 1, "chain_res", 1'b1, 32'd6, SH, 1'b0, 1'b0);
    idle(1);

    // negative subtraction, then operate on a negative SHOW result
    clr(); num(3); oper(4'hE); num(5);
    eq(); expect_at(le + 1, "sub_neg", 1'b1, 32'hFFFF_FFFE, SH, 1'b0, 1'b0);
    idle(1);
    oper(4'hE); num(8);
    eq(); expect_at(le + 1, "show_sub", 1'b1, 32'hFFFF_FFF6, SH, 1'b0, 1'b0);
    idle(1);

    // -5 x 0 gives plain zero
    clr(); neg(1'b1); num(5); ex("neg5", 32'hFFFF_FFFB, EA);
    oper(4'hD); num(0);
    eq(); expect_at(le + 14, "mul_zero", 1'b1, 32'd0, SH, 1'b0, 1'b0);
    idle(14);

    // resetPulse on the 5th COMPUTE cycle aborts the multiply
    clr(); num(3); oper(4'hD); num(4);
    eq(); le_eq = le;
    for (int i = 0; i < 5; i++) expect_at(le_eq + i, "abort_busy", 1'b0, '0, CP, 1'b1, 1'b0);
    idle(4);
    tick(); resetPulse = 5'h10;
    expect_at(le_eq + 5, "abort", 1'b1, 32'd0, EA, 1'b0, 1'b0);
    idle(10); ex("abort_stays", 0, EA);

    // clear beats a coincident digit
    num(6); ex("d6", 6, EA);
    tick(); clearPulse = 5'h10; numberPulse = 5'h17; ex("clr_beats_num", 0, EA);
    num(8); ex("after_clr", 8, EA);

    idle(3);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
